// File: rtl/flood_engine.sv
// Flood-it game engine: loads a square board from a generator, grows the flooded region from (0,0), scores moves.
// Latency: board load SIZE*SIZE cycles, each grow sweep SIZE*SIZE cycles, one check cycle before PLAY/WIN/LOSE.
// Backpressure: waits in REQ until BOARD_READY; moves are accepted only in PLAY and dropped otherwise.
//
// Ports:
//   CLOCK, RESET (async, active-high)
//   START_GAME, final_SIZE, final_COLOR_NUM, MOVE_LIMIT      -- game settings, sampled on START_GAME
//   INITIALIZE_BOARD, BOARD_READY, RD_ROW, RD_COL, RD_COLOR  -- board generator handshake and read port
//   MOVE_VALID, MOVE_COLOR                                   -- player move strobe
//   DISP_ROW, DISP_COL, DISP_COLOR, DISP_FLOODED             -- combinational display read port
//   BUSY, MOVE_COUNT, WIN, LOSE                              -- status
module flood_engine #(
    parameter int MAX_SIZE = 26,
    parameter int MOVE_W   = 6
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START_GAME,
    input  logic [4:0]        final_SIZE,
    input  logic [3:0]        final_COLOR_NUM,
    input  logic [MOVE_W-1:0] MOVE_LIMIT,
    output logic              INITIALIZE_BOARD,
    input  logic              BOARD_READY,
    output logic [4:0]        RD_ROW,
    output logic [4:0]        RD_COL,
    input  logic [2:0]        RD_COLOR,
    input  logic              MOVE_VALID,
    input  logic [2:0]        MOVE_COLOR,
    input  logic [4:0]        DISP_ROW,
    input  logic [4:0]        DISP_COL,
    output logic [2:0]        DISP_COLOR,
    output logic              DISP_FLOODED,
    output logic              BUSY,
    output logic [MOVE_W-1:0] MOVE_COUNT,
    output logic              WIN,
    output logic              LOSE
);

    localparam logic [4:0] MAX_SZ = 5'(MAX_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_LOAD, S_GROW, S_CHECK, S_PLAY, S_WIN, S_LOSE
    } state_t;

    state_t            state_q;
    logic [4:0]        size_q;
    logic [3:0]        ncol_q;
    logic [MOVE_W-1:0] limit_q;
    logic [MOVE_W-1:0] count_q;
    logic [2:0]        c_q;          // current flood colour
    logic              changed_q;    // some cell joined the region during this sweep
    logic [4:0]        row_q;        // shared load / sweep position
    logic [4:0]        col_q;
    logic              init_q;
    logic              win_q;
    logic              lose_q;
    logic [9:0]        flood_cnt_q;  // number of flooded cells, avoids a full-board reduction in CHECK

    logic [2:0]        color_q [MAX_SIZE][MAX_SIZE];
    logic              flood_q [MAX_SIZE][MAX_SIZE];

    // Scan position bookkeeping
    logic       col_last, row_last, cell_last;
    logic [4:0] row_d, col_d;
    logic [4:0] r_up, r_dn, c_lf, c_rt;
    logic       cur_fl, nbr_fl, grow_hit;
    logic [2:0] cur_col;
    logic [9:0] size_sq;
    logic       all_fl;
    logic       move_ok;
    logic       disp_in;

    always_comb begin
        col_last  = (col_q == size_q - 5'd1);
        row_last  = (row_q == size_q - 5'd1);
        cell_last = col_last && row_last;
        col_d     = col_last ? 5'd0 : col_q + 5'd1;
        row_d     = col_last ? row_q + 5'd1 : row_q;

        // Neighbour indices are clamped so array reads stay in bounds; the
        // edge qualifiers below discard the clamped reads.
        r_up = (row_q == 5'd0) ? row_q : row_q - 5'd1;
        r_dn = row_last        ? row_q : row_q + 5'd1;
        c_lf = (col_q == 5'd0) ? col_q : col_q - 5'd1;
        c_rt = col_last        ? col_q : col_q + 5'd1;

        cur_fl  = flood_q[row_q][col_q];
        cur_col = color_q[row_q][col_q];
        nbr_fl  = ((row_q != 5'd0) && flood_q[r_up][col_q]) ||
                  (!row_last       && flood_q[r_dn][col_q]) ||
                  ((col_q != 5'd0) && flood_q[row_q][c_lf]) ||
                  (!col_last       && flood_q[row_q][c_rt]);
        grow_hit = !cur_fl && (cur_col == c_q) && nbr_fl;

        size_sq = 10'(size_q) * 10'(size_q);
        all_fl  = (flood_cnt_q == size_sq);

        move_ok = MOVE_VALID && ({1'b0, MOVE_COLOR} < ncol_q) &&
                  (MOVE_COLOR != color_q[0][0]);

        disp_in = (DISP_ROW < size_q) && (DISP_COL < size_q);
    end

    assign DISP_COLOR       = disp_in ? color_q[DISP_ROW][DISP_COL] : 3'd0;
    assign DISP_FLOODED     = disp_in ? flood_q[DISP_ROW][DISP_COL] : 1'b0;
    assign BUSY             = (state_q != S_IDLE) && (state_q != S_PLAY) &&
                              (state_q != S_WIN)  && (state_q != S_LOSE);
    assign INITIALIZE_BOARD = init_q;
    assign RD_ROW           = row_q;
    assign RD_COL           = col_q;
    assign MOVE_COUNT       = count_q;
    assign WIN              = win_q;
    assign LOSE             = lose_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            size_q      <= 5'd0;
            ncol_q      <= 4'd0;
            limit_q     <= '0;
            count_q     <= '0;
            c_q         <= 3'd0;
            changed_q   <= 1'b0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            init_q      <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            flood_cnt_q <= 10'd0;
            for (int r = 0; r < MAX_SIZE; r++) begin
                for (int c = 0; c < MAX_SIZE; c++) begin
                    color_q[r][c] <= 3'd0;
                    flood_q[r][c] <= 1'b0;
                end
            end
        end else if (START_GAME) begin
            // A new game overrides whatever is in progress.
            size_q      <= (final_SIZE > MAX_SZ) ? MAX_SZ : final_SIZE;
            ncol_q      <= final_COLOR_NUM;
            limit_q     <= MOVE_LIMIT;
            count_q     <= '0;
            changed_q   <= 1'b0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            init_q      <= 1'b1;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            flood_cnt_q <= 10'd0;
            state_q     <= S_REQ;
            for (int r = 0; r < MAX_SIZE; r++) begin
                for (int c = 0; c < MAX_SIZE; c++) begin
                    flood_q[r][c] <= 1'b0;
                end
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (size_q == 5'd0) begin
                        init_q  <= 1'b0;
                        win_q   <= 1'b1;
                        state_q <= S_WIN;
                    end else if (BOARD_READY) begin
                        row_q   <= 5'd0;
                        col_q   <= 5'd0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    color_q[row_q][col_q] <= RD_COLOR;
                    if (cell_last) begin
                        init_q        <= 1'b0;
                        flood_q[0][0] <= 1'b1;
                        flood_cnt_q   <= 10'd1;
                        // On a 1x1 board cell (0,0) is being written this very cycle.
                        c_q           <= (row_q == 5'd0 && col_q == 5'd0) ? RD_COLOR : color_q[0][0];
                        changed_q     <= 1'b0;
                        row_q         <= 5'd0;
                        col_q         <= 5'd0;
                        state_q       <= S_GROW;
                    end else begin
                        row_q <= row_d;
                        col_q <= col_d;
                    end
                end
                S_GROW: begin
                    if (cur_fl) begin
                        color_q[row_q][col_q] <= c_q;
                    end else if (grow_hit) begin
                        color_q[row_q][col_q] <= c_q;
                        flood_q[row_q][col_q] <= 1'b1;
                        flood_cnt_q           <= flood_cnt_q + 10'd1;
                    end
                    if (cell_last) begin
                        row_q     <= 5'd0;
                        col_q     <= 5'd0;
                        changed_q <= 1'b0;
                        // The final cell of a sweep can itself be the change.
                        if (!(changed_q || grow_hit)) begin
                            state_q <= S_CHECK;
                        end
                    end else begin
                        row_q <= row_d;
                        col_q <= col_d;
                        if (grow_hit) begin
                            changed_q <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (all_fl) begin
                        win_q   <= 1'b1;
                        state_q <= S_WIN;
                    end else if ((count_q == limit_q) && (limit_q != '0)) begin
                        lose_q  <= 1'b1;
                        state_q <= S_LOSE;
                    end else begin
                        state_q <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (move_ok) begin
                        c_q       <= MOVE_COLOR;
                        if (count_q != '1) begin
                            count_q <= count_q + MOVE_W'(1);
                        end
                        row_q     <= 5'd0;
                        col_q     <= 5'd0;
                        changed_q <= 1'b0;
                        state_q   <= S_GROW;
                    end
                end
                default: begin
                    // IDLE, WIN and LOSE hold until START_GAME or RESET.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flood_engine.sv
module tb_flood_engine;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       START_GAME;
    logic [4:0] final_SIZE;
    logic [3:0] final_COLOR_NUM;
    logic [5:0] MOVE_LIMIT;
    logic       INITIALIZE_BOARD;
    logic       BOARD_READY;
    logic [4:0] RD_ROW, RD_COL;
    logic [2:0] RD_COLOR;
    logic       MOVE_VALID;
    logic [2:0] MOVE_COLOR;
    logic [4:0] DISP_ROW, DISP_COL;
    logic [2:0] DISP_COLOR;
    logic       DISP_FLOODED;
    logic       BUSY;
    logic [5:0] MOVE_COUNT;
    logic       WIN, LOSE;

    logic [2:0] board [32][32];
    assign RD_COLOR = board[RD_ROW][RD_COL];

    int tests = 0;
    int fails = 0;

    always #5 CLOCK = ~CLOCK;

    flood_engine #(.MAX_SIZE(26), .MOVE_W(6)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START_GAME(START_GAME),
        .final_SIZE(final_SIZE), .final_COLOR_NUM(final_COLOR_NUM), .MOVE_LIMIT(MOVE_LIMIT),
        .INITIALIZE_BOARD(INITIALIZE_BOARD), .BOARD_READY(BOARD_READY),
        .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_COLOR(RD_COLOR),
        .MOVE_VALID(MOVE_VALID), .MOVE_COLOR(MOVE_COLOR),
        .DISP_ROW(DISP_ROW), .DISP_COL(DISP_COL), .DISP_COLOR(DISP_COLOR), .DISP_FLOODED(DISP_FLOODED),
        .BUSY(BUSY), .MOVE_COUNT(MOVE_COUNT), .WIN(WIN), .LOSE(LOSE)
    );

    // ---------------- stimulus helpers ----------------
    task automatic fill(input logic [2:0] v);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = v;
    endtask

    // Leaves the caller one negedge after the START_GAME edge (state REQ).
    task automatic start_game(input logic [4:0] sz, input logic [3:0] ncol, input logic [5:0] lim);
        @(negedge CLOCK);
        final_SIZE = sz; final_COLOR_NUM = ncol; MOVE_LIMIT = lim; START_GAME = 1'b1;
        @(negedge CLOCK);
        START_GAME = 1'b0;
    endtask

    task automatic do_move(input logic [2:0] col);
        @(negedge CLOCK);
        MOVE_VALID = 1'b1; MOVE_COLOR = col;
        @(negedge CLOCK);
        MOVE_VALID = 1'b0;
    endtask

    // Counts negedges with BUSY high; -1 when the budget runs out.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 5000; i++) begin
            if (!BUSY) begin cyc = i; break; end
            @(negedge CLOCK);
        end
    endtask

    task automatic peek(input logic [4:0] r, input logic [4:0] c);
        DISP_ROW = r; DISP_COL = c;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b1; START_GAME = 1'b0; BOARD_READY = 1'b1; MOVE_VALID = 1'b0; MOVE_COLOR = 3'd0;
        final_SIZE = 5'd0; final_COLOR_NUM = 4'd0; MOVE_LIMIT = 6'd0; DISP_ROW = 5'd0; DISP_COL = 5'd0;
        fill(3'd0);
        repeat (2) @(negedge CLOCK);
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests++; if (INITIALIZE_BOARD !== 1'b0) begin fails++; $display("FAIL reset_init: got %b expected 0", INITIALIZE_BOARD); end
        tests++; if (MOVE_COUNT !== 6'd0 || WIN !== 1'b0 || LOSE !== 1'b0) begin fails++;
            $display("FAIL reset_status: got cnt=%0d win=%b lose=%b expected 0 0 0", MOVE_COUNT, WIN, LOSE); end
        tests++; if (RD_ROW !== 5'd0 || RD_COL !== 5'd0) begin fails++;
            $display("FAIL reset_rdaddr: got %0d,%0d expected 0,0", RD_ROW, RD_COL); end
        tests++; if (DISP_COLOR !== 3'd0 || DISP_FLOODED !== 1'b0) begin fails++;
            $display("FAIL reset_disp: got %0d/%b expected 0/0", DISP_COLOR, DISP_FLOODED); end
        RESET = 1'b0;
        do_move(3'd1);
        repeat (3) @(negedge CLOCK);
        tests++; if (BUSY !== 1'b0 || MOVE_COUNT !== 6'd0 || INITIALIZE_BOARD !== 1'b0) begin fails++;
            $display("FAIL idle_hold: got busy=%b cnt=%0d init=%b expected 0 0 0", BUSY, MOVE_COUNT, INITIALIZE_BOARD); end
    endtask

    task automatic test_uniform();
        int cyc;
        fill(3'd2);
        start_game(5'd4, 4'd3, 6'd0);
        tests++; if (INITIALIZE_BOARD !== 1'b1) begin fails++; $display("FAIL uni_init_req: got %b expected 1", INITIALIZE_BOARD); end
        wait_done(cyc);
        // REQ 1 + LOAD 16 + two sweeps of 16 + CHECK 1
        tests++; if (cyc !== 50) begin fails++; $display("FAIL uni_busy_cycles: got %0d expected 50", cyc); end
        tests++; if (WIN !== 1'b1 || LOSE !== 1'b0 || MOVE_COUNT !== 6'd0) begin fails++;
            $display("FAIL uni_result: got win=%b lose=%b cnt=%0d expected 1 0 0", WIN, LOSE, MOVE_COUNT); end
        tests++; if (INITIALIZE_BOARD !== 1'b0) begin fails++; $display("FAIL uni_init_drop: got %b expected 0", INITIALIZE_BOARD); end
        peek(5'd3, 5'd3);
        tests++; if (DISP_FLOODED !== 1'b1 || DISP_COLOR !== 3'd2) begin fails++;
            $display("FAIL uni_disp33: got %b/%0d expected 1/2", DISP_FLOODED, DISP_COLOR); end
        peek(5'd4, 5'd0);
        tests++; if (DISP_FLOODED !== 1'b0 || DISP_COLOR !== 3'd0) begin fails++;
            $display("FAIL uni_disp_oor: got %b/%0d expected 0/0", DISP_FLOODED, DISP_COLOR); end
        do_move(3'd1);
        repeat (2) @(negedge CLOCK);
        tests++; if (WIN !== 1'b1 || MOVE_COUNT !== 6'd0 || BUSY !== 1'b0) begin fails++;
            $display("FAIL uni_win_hold: got win=%b cnt=%0d busy=%b expected 1 0 0", WIN, MOVE_COUNT, BUSY); end
    endtask

    task automatic test_move_win();
        int cyc;
        fill(3'd1); board[0][0] = 3'd0;
        start_game(5'd2, 4'd3, 6'd0);
        wait_done(cyc);
        tests++; if (cyc !== 10 || WIN !== 1'b0) begin fails++;
            $display("FAIL mw_play: got cyc=%0d win=%b expected 10 0", cyc, WIN); end
        peek(5'd0, 5'd1);
        tests++; if (DISP_FLOODED !== 1'b0) begin fails++; $display("FAIL mw_pre_flood01: got %b expected 0", DISP_FLOODED); end
        do_move(3'd1);
        wait_done(cyc);
        tests++; if (cyc < 0 || MOVE_COUNT !== 6'd1 || WIN !== 1'b1) begin fails++;
            $display("FAIL mw_result: got cyc=%0d cnt=%0d win=%b expected >=0 1 1", cyc, MOVE_COUNT, WIN); end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                peek(5'(r), 5'(c));
                tests++; if (DISP_FLOODED !== 1'b1 || DISP_COLOR !== 3'd1) begin fails++;
                    $display("FAIL mw_cell_%0d_%0d: got %b/%0d expected 1/1", r, c, DISP_FLOODED, DISP_COLOR); end
            end
    endtask

    task automatic test_lose();
        int cyc;
        fill(3'd0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                board[r][c] = 3'((r + c) % 2);
        start_game(5'd3, 4'd3, 6'd1);
        wait_done(cyc);
        do_move(3'd1);
        wait_done(cyc);
        tests++; if (cyc < 0 || MOVE_COUNT !== 6'd1 || WIN !== 1'b0 || LOSE !== 1'b1) begin fails++;
            $display("FAIL lose_result: got cyc=%0d cnt=%0d win=%b lose=%b expected >=0 1 0 1", cyc, MOVE_COUNT, WIN, LOSE); end
        peek(5'd0, 5'd1);
        tests++; if (DISP_FLOODED !== 1'b1) begin fails++; $display("FAIL lose_flood01: got %b expected 1", DISP_FLOODED); end
        peek(5'd1, 5'd2);
        tests++; if (DISP_FLOODED !== 1'b0) begin fails++; $display("FAIL lose_flood12: got %b expected 0", DISP_FLOODED); end
        do_move(3'd0);
        repeat (2) @(negedge CLOCK);
        tests++; if (LOSE !== 1'b1 || MOVE_COUNT !== 6'd1 || BUSY !== 1'b0) begin fails++;
            $display("FAIL lose_hold: got lose=%b cnt=%0d busy=%b expected 1 1 0", LOSE, MOVE_COUNT, BUSY); end
    endtask

    task automatic test_invalid_moves();
        int cyc;
        fill(3'd0); board[0][0] = 3'd2;
        start_game(5'd2, 4'd3, 6'd0);
        wait_done(cyc);
        do_move(3'd2);
        tests++; if (MOVE_COUNT !== 6'd0 || BUSY !== 1'b0) begin fails++;
            $display("FAIL inv_same: got cnt=%0d busy=%b expected 0 0", MOVE_COUNT, BUSY); end
        do_move(3'd5);
        tests++; if (MOVE_COUNT !== 6'd0 || BUSY !== 1'b0) begin fails++;
            $display("FAIL inv_range5: got cnt=%0d busy=%b expected 0 0", MOVE_COUNT, BUSY); end
        do_move(3'd3);
        tests++; if (MOVE_COUNT !== 6'd0 || BUSY !== 1'b0) begin fails++;
            $display("FAIL inv_range3: got cnt=%0d busy=%b expected 0 0", MOVE_COUNT, BUSY); end
        do_move(3'd0);
        wait_done(cyc);
        tests++; if (cyc < 0 || MOVE_COUNT !== 6'd1 || WIN !== 1'b1) begin fails++;
            $display("FAIL inv_then_valid: got cyc=%0d cnt=%0d win=%b expected >=0 1 1", cyc, MOVE_COUNT, WIN); end
    endtask

    task automatic test_reset_mid_grow();
        fill(3'd2);
        start_game(5'd4, 4'd3, 6'd0);
        repeat (20) @(negedge CLOCK);
        MOVE_VALID = 1'b1; MOVE_COLOR = 3'd1;
        @(negedge CLOCK);
        MOVE_VALID = 1'b0;
        repeat (4) @(negedge CLOCK);
        tests++; if (BUSY !== 1'b1 || MOVE_COUNT !== 6'd0) begin fails++;
            $display("FAIL busy_move_ignored: got busy=%b cnt=%0d expected 1 0", BUSY, MOVE_COUNT); end
        #2 RESET = 1'b1;
        #1;
        DISP_ROW = 5'd0; DISP_COL = 5'd0;
        #1;
        tests++; if (BUSY !== 1'b0 || INITIALIZE_BOARD !== 1'b0 || WIN !== 1'b0 || LOSE !== 1'b0 ||
                     MOVE_COUNT !== 6'd0 || RD_ROW !== 5'd0 || RD_COL !== 5'd0 ||
                     DISP_COLOR !== 3'd0 || DISP_FLOODED !== 1'b0) begin fails++;
            $display("FAIL rst_mid_grow: got busy=%b init=%b win=%b lose=%b cnt=%0d rd=%0d,%0d disp=%0d/%b expected all 0",
                     BUSY, INITIALIZE_BOARD, WIN, LOSE, MOVE_COUNT, RD_ROW, RD_COL, DISP_COLOR, DISP_FLOODED); end
        @(negedge CLOCK);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rst_stay_idle: got %b expected 0", BUSY); end
    endtask

    task automatic test_restart_mid_load();
        int cyc;
        fill(3'd2);
        start_game(5'd4, 4'd3, 6'd0);
        repeat (5) @(negedge CLOCK);
        tests++; if (RD_ROW !== 5'd1 || RD_COL !== 5'd0) begin fails++;
            $display("FAIL load_raster: got %0d,%0d expected 1,0", RD_ROW, RD_COL); end
        start_game(5'd3, 4'd3, 6'd0);
        tests++; if (INITIALIZE_BOARD !== 1'b1 || RD_ROW !== 5'd0 || RD_COL !== 5'd0 || BUSY !== 1'b1) begin fails++;
            $display("FAIL restart_load: got init=%b rd=%0d,%0d busy=%b expected 1 0,0 1", INITIALIZE_BOARD, RD_ROW, RD_COL, BUSY); end
        wait_done(cyc);
        tests++; if (cyc !== 29 || WIN !== 1'b1) begin fails++;
            $display("FAIL restart_done: got cyc=%0d win=%b expected 29 1", cyc, WIN); end
        peek(5'd3, 5'd3);
        tests++; if (DISP_FLOODED !== 1'b0 || DISP_COLOR !== 3'd0) begin fails++;
            $display("FAIL restart_oor: got %b/%0d expected 0/0", DISP_FLOODED, DISP_COLOR); end
    endtask

    task automatic test_spiral();
        int cyc;
        int bad;
        logic [5:0] zrow [6];
        zrow[0] = 6'b111111; zrow[1] = 6'b100000; zrow[2] = 6'b101111;
        zrow[3] = 6'b101001; zrow[4] = 6'b100001; zrow[5] = 6'b111111;
        fill(3'd1);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                board[r][c] = zrow[r][c] ? 3'd0 : 3'd1;
        start_game(5'd6, 4'd3, 6'd0);
        wait_done(cyc);
        // REQ 1 + LOAD 36 + ten sweeps of 36 + CHECK 1
        tests++; if (cyc !== 398) begin fails++; $display("FAIL spiral_cycles: got %0d expected 398", cyc); end
        tests++; if (WIN !== 1'b0 || LOSE !== 1'b0 || BUSY !== 1'b0) begin fails++;
            $display("FAIL spiral_play: got win=%b lose=%b busy=%b expected 0 0 0", WIN, LOSE, BUSY); end
        bad = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                peek(5'(r), 5'(c));
                tests++; if (DISP_FLOODED !== zrow[r][c]) begin fails++; bad++;
                    if (bad < 6) $display("FAIL spiral_cell_%0d_%0d: got %b expected %b", r, c, DISP_FLOODED, zrow[r][c]); end
            end
    endtask

    task automatic test_size_edges();
        int cyc;
        BOARD_READY = 1'b0;
        start_game(5'd0, 4'd3, 6'd0);
        wait_done(cyc);
        tests++; if (cyc !== 1 || WIN !== 1'b1) begin fails++;
            $display("FAIL size0: got cyc=%0d win=%b expected 1 1", cyc, WIN); end
        fill(3'd1);
        start_game(5'd1, 4'd3, 6'd0);
        repeat (3) @(negedge CLOCK);
        tests++; if (BUSY !== 1'b1 || INITIALIZE_BOARD !== 1'b1) begin fails++;
            $display("FAIL req_wait: got busy=%b init=%b expected 1 1", BUSY, INITIALIZE_BOARD); end
        BOARD_READY = 1'b1;
        wait_done(cyc);
        tests++; if (cyc !== 4 || WIN !== 1'b1) begin fails++;
            $display("FAIL size1: got cyc=%0d win=%b expected 4 1", cyc, WIN); end
        fill(3'd3);
        start_game(5'd31, 4'd4, 6'd0);
        wait_done(cyc);
        tests++; if (cyc !== 2030 || WIN !== 1'b1) begin fails++;
            $display("FAIL size_clamp: got cyc=%0d win=%b expected 2030 1", cyc, WIN); end
        peek(5'd25, 5'd25);
        tests++; if (DISP_FLOODED !== 1'b1 || DISP_COLOR !== 3'd3) begin fails++;
            $display("FAIL clamp_corner: got %b/%0d expected 1/3", DISP_FLOODED, DISP_COLOR); end
        peek(5'd26, 5'd0);
        tests++; if (DISP_FLOODED !== 1'b0 || DISP_COLOR !== 3'd0) begin fails++;
            $display("FAIL clamp_oor: got %b/%0d expected 0/0", DISP_FLOODED, DISP_COLOR); end
    endtask

    task automatic test_saturate();
        int cyc;
        int lost;
        fill(3'd7); board[0][0] = 3'd0;
        start_game(5'd2, 4'd7, 6'd0);
        wait_done(cyc);
        lost = 0;
        for (int i = 0; i < 63; i++) begin
            do_move((i % 2 == 0) ? 3'd1 : 3'd2);
            wait_done(cyc);
            if (cyc < 0) lost++;
        end
        tests++; if (lost !== 0 || MOVE_COUNT !== 6'd63 || LOSE !== 1'b0 || WIN !== 1'b0) begin fails++;
            $display("FAIL sat_63: got lost=%0d cnt=%0d lose=%b win=%b expected 0 63 0 0", lost, MOVE_COUNT, LOSE, WIN); end
        do_move(3'd2);
        wait_done(cyc);
        tests++; if (cyc < 0 || MOVE_COUNT !== 6'd63 || BUSY !== 1'b0) begin fails++;
            $display("FAIL sat_hold: got cyc=%0d cnt=%0d busy=%b expected >=0 63 0", cyc, MOVE_COUNT, BUSY); end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_move_win();
        test_lose();
        test_invalid_moves();
        test_reset_mid_grow();
        test_restart_mid_load();
        test_spiral();
        test_size_edges();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
